// File: rtl/dla_platform_reset_sequencer.sv
// dla_platform_reset_sequencer: releases NUM_STAGES resets in index order, each gated on the previous stage's ready,
// with a sticky ready-timeout flag and a software reset req/ack handshake serviced only in RUN.
module dla_platform_reset_sequencer #(
  parameter int NUM_STAGES         = 4,
  parameter int HOLD_CYCLES        = 16,
  parameter int STAGE_GAP_CYCLES   = 8,
  parameter int ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_sw_reset_req,
  output logic                  o_sw_reset_ack,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  output logic [NUM_STAGES-1:0] o_stage_resetn,
  output logic                  o_all_released,
  output logic                  o_timeout_err
);
  localparam int MHG  = HOLD_CYCLES > STAGE_GAP_CYCLES ? HOLD_CYCLES : STAGE_GAP_CYCLES;
  localparam int MAXC = MHG > ACK_TIMEOUT_CYCLES ? MHG : ACK_TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_GAP, S_RUN} state_t;
  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [SW-1:0]         r_stage, w_stage;
  logic [NUM_STAGES-1:0] r_resetn, w_resetn;
  logic                  r_all, w_all, r_ack, w_ack, r_err, w_err, r_sw, w_sw;
  logic                  w_last, w_rdy;
  assign w_last = r_stage == SW'(NUM_STAGES - 1);
  assign w_rdy  = i_stage_ready[r_stage];
  // The release of stage k happens on the transition into WAIT(k); the last stage's GAP is a single cycle into RUN.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_stage  = r_stage;
    w_resetn = r_resetn;
    w_all    = r_all;
    w_ack    = 1'b0;
    w_err    = r_err;
    w_sw     = r_sw;
    case (r_state)
      S_HOLD:
        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
          w_state     = S_WAIT;
          w_cnt       = '0;
          w_stage     = '0;
          w_resetn[0] = 1'b1;
        end else w_cnt = r_cnt + 1'b1;
      S_WAIT:
        if (w_rdy || r_cnt == CW'(ACK_TIMEOUT_CYCLES - 1)) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_err   = r_err | ~w_rdy;
        end else w_cnt = r_cnt + 1'b1;
      S_GAP:
        if (w_last) begin
          w_state = S_RUN;
          w_cnt   = '0;
          w_all   = 1'b1;
          w_ack   = r_sw;
          w_sw    = 1'b0;
        end else if (r_cnt == CW'(STAGE_GAP_CYCLES)) begin
          w_state  = S_WAIT;
          w_cnt    = '0;
          w_stage  = r_stage + 1'b1;
          w_resetn = r_resetn | (NUM_STAGES'(1) << (r_stage + 1'b1));
        end else w_cnt = r_cnt + 1'b1;
      S_RUN:
        if (i_sw_reset_req) begin
          w_state  = S_HOLD;
          w_cnt    = '0;
          w_resetn = '0;
          w_all    = 1'b0;
          w_sw     = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) begin
      r_state  <= S_HOLD;
      r_cnt    <= '0;
      r_stage  <= '0;
      r_resetn <= '0;
      r_all    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_sw     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_stage  <= w_stage;
      r_resetn <= w_resetn;
      r_all    <= w_all;
      r_ack    <= w_ack;
      r_err    <= w_err;
      r_sw     <= w_sw;
    end
  assign o_stage_resetn = r_resetn;
  assign o_all_released = r_all;
  assign o_sw_reset_ack = r_ack;
  assign o_timeout_err  = r_err;
endmodule
